pe_stream_checker: RTL and testbench

//  Self-checking output monitor for the interpolation-filter benches (luma and chroma PEs).

---
 rtl/pe_stream_checker.sv | 144 ++++++++++++++
 tb/tb_pe_stream_checker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_stream_checker.sv
// Golden-vs-DUT stream checker for the interpolation-filter PE benches: golden FIFO,
// lane-wise compare, watchdog and PASS/FAIL end-of-test FSM. Optional PE_CHECK_FIRST_ERR_EN.

module pe_lane_cmp #(
  parameter int DW = 17
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          ne
);
  assign ne = (a != b);
endmodule

module pe_stream_checker #(
  parameter int DW      = 17,
  parameter int LANES   = 1,
  parameter int DEPTH   = 16,
  parameter int TOTAL   = 64,
  parameter int TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  exp_valid,
  input  logic [LANES*DW-1:0]   exp_data,
  output logic                  exp_ready,
  input  logic                  Vout,
  input  logic [LANES*DW-1:0]   o,
  output logic [LANES-1:0]      lane_err,
  output logic [15:0]           n_checked,
  output logic [15:0]           n_errors,
  output logic                  end_sim,
  output logic                  pass
`ifdef PE_CHECK_FIRST_ERR_EN
  ,
  output logic [15:0]           first_err_idx,
  output logic [LANES*DW-1:0]   first_err_exp,
  output logic [LANES*DW-1:0]   first_err_got,
  output logic                  first_err_vld
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  localparam logic [15:0]   LAST_BEAT = 16'(TOTAL - 1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, PASS, FAIL} state_t;

  state_t                    state, state_nx;
  logic [LANES*DW-1:0]       mem [DEPTH];
  logic [AW:0]               wptr, rptr, wptr_nx, rptr_nx;
  logic [WW-1:0]             wdog;
  logic [LANES*DW-1:0]       head;
  logic [LANES-1:0][DW-1:0]  head_l, o_l;
  logic [LANES-1:0]          lane_ne;
  logic live, active, empty, full, full_nx;
  logic do_chk, under, do_pop, do_push, bad, wd_hit;

  assign head   = mem[rptr[AW-1:0]];
  assign head_l = head;
  assign o_l    = o;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe_lane_cmp #(.DW(DW)) u_cmp (.a(head_l[i]), .b(o_l[i]), .ne(lane_ne[i]));
  end

  always_comb begin
    live    = (state == IDLE) || (state == RUN) || (state == DRAIN);
    active  = (state == IDLE) || (state == RUN);
    empty   = (wptr == rptr);
    full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    do_chk  = active && Vout;
    // A push landing in an empty FIFO is not visible to a same-cycle check.
    under   = do_chk && empty;
    do_pop  = do_chk && !empty;
    // While full, a same-cycle pop frees the slot the push lands in.
    do_push = live && exp_valid && (!full || do_pop);
    bad     = under || (do_chk && (|lane_ne));
    wd_hit  = (state == RUN) && !Vout && !empty && (wdog >= WD_LAST);
    wptr_nx = wptr + {{AW{1'b0}}, do_push};
    rptr_nx = rptr + {{AW{1'b0}}, do_pop};
    full_nx = (wptr_nx[AW] != rptr_nx[AW]) && (wptr_nx[AW-1:0] == rptr_nx[AW-1:0]);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (under) state_nx = FAIL;
               else if (do_push || Vout) state_nx = RUN;
      RUN:     if (under) state_nx = FAIL;
               else if (do_chk && n_checked == LAST_BEAT) state_nx = DRAIN;
               else if (wd_hit) state_nx = FAIL;
      DRAIN:   state_nx = (n_errors == 16'd0) ? PASS : FAIL;
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wptr[AW-1:0]] <= exp_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wptr      <= '0;
      rptr      <= '0;
      wdog      <= '0;
      exp_ready <= 1'b0;
      lane_err  <= '0;
      n_checked <= '0;
      n_errors  <= '0;
      end_sim   <= 1'b0;
      pass      <= 1'b0;
`ifdef PE_CHECK_FIRST_ERR_EN
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
      first_err_vld <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      wptr      <= wptr_nx;
      rptr      <= rptr_nx;
      exp_ready <= !full_nx;
      lane_err  <= under ? '1 : (do_chk ? lane_ne : '0);
      if (do_chk) n_checked <= n_checked + 16'd1;
      if (bad && n_errors != 16'hFFFF) n_errors <= n_errors + 16'd1;
      if (state != RUN || Vout) wdog <= '0;
      else if (!empty && wdog != WD_MAX) wdog <= wdog + WW'(1);
      if (state_nx == PASS || state_nx == FAIL) begin
        end_sim <= 1'b1;
        pass    <= (state_nx == PASS);
      end
`ifdef PE_CHECK_FIRST_ERR_EN
      if (bad && !first_err_vld) begin
        first_err_idx <= n_checked;
        first_err_exp <= head;
        first_err_got <= o;
        first_err_vld <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_pe_stream_checker.sv
// Scoreboard bench for pe_stream_checker: a 1-lane and a 4-lane instance, directed vectors.

module tb_pe_stream_checker;
  localparam int DW = 17;
  localparam int DEPTH = 4;
  localparam int TOTAL = 8;
  localparam int TMO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst1 = 1'b1, ev1 = 1'b0, vo1 = 1'b0;
  logic [DW-1:0]   ed1 = '0, o1 = '0;
  logic            er1, le1, es1, ps1;
  logic [15:0]     nc1, ne1;
  logic            rst4 = 1'b1, ev4 = 1'b0, vo4 = 1'b0;
  logic [4*DW-1:0] ed4 = '0, o4 = '0;
  logic            er4, es4, ps4;
  logic [3:0]      le4;
  logic [15:0]     nc4, ne4;
`ifdef PE_CHECK_FIRST_ERR_EN
  logic [15:0]     fi1, fi4;
  logic [DW-1:0]   fx1, fg1;
  logic [4*DW-1:0] fx4, fg4;
  logic            fv1, fv4;
`endif

  pe_stream_checker #(.DW(DW), .LANES(1), .DEPTH(DEPTH), .TOTAL(TOTAL), .TIMEOUT(TMO)) dut1 (
    .clk(clk), .reset(rst1), .exp_valid(ev1), .exp_data(ed1), .exp_ready(er1),
    .Vout(vo1), .o(o1), .lane_err(le1), .n_checked(nc1), .n_errors(ne1),
    .end_sim(es1), .pass(ps1)
`ifdef PE_CHECK_FIRST_ERR_EN
    , .first_err_idx(fi1), .first_err_exp(fx1), .first_err_got(fg1), .first_err_vld(fv1)
`endif
  );

  pe_stream_checker #(.DW(DW), .LANES(4), .DEPTH(DEPTH), .TOTAL(TOTAL), .TIMEOUT(TMO)) dut4 (
    .clk(clk), .reset(rst4), .exp_valid(ev4), .exp_data(ed4), .exp_ready(er4),
    .Vout(vo4), .o(o4), .lane_err(le4), .n_checked(nc4), .n_errors(ne4),
    .end_sim(es4), .pass(ps4)
`ifdef PE_CHECK_FIRST_ERR_EN
    , .first_err_idx(fi4), .first_err_exp(fx4), .first_err_got(fg4), .first_err_vld(fv4)
`endif
  );

  typedef struct { logic [3:0] le; int nc; int ne; } exp_t;
  exp_t q1[$], q4[$];
  int checks = 0, errors = 0;
  logic trk1 = 1'b1, trk4 = 1'b1, seen1 = 1'b0, seen4 = 1'b0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Monitors: a beat presented at a posedge is scored at the following negedge.
  always @(posedge clk) begin
    seen1 <= trk1 && vo1 && !rst1;
    seen4 <= trk4 && vo4 && !rst4;
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (seen1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL mon1_unexpected got=beat exp=none");
      end else begin
        e = q1.pop_front();
        chk("mon1_lane_err", 128'(le1), 128'(e.le));
        chk("mon1_n_checked", 128'(nc1), 128'(e.nc));
        chk("mon1_n_errors", 128'(ne1), 128'(e.ne));
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (seen4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL mon4_unexpected got=beat exp=none");
      end else begin
        e = q4.pop_front();
        chk("mon4_lane_err", 128'(le4), 128'(e.le));
        chk("mon4_n_checked", 128'(nc4), 128'(e.nc));
        chk("mon4_n_errors", 128'(ne4), 128'(e.ne));
      end
    end
  end

  task automatic cyc1(input logic ev, input int ed, input logic vo, input int od,
                      input logic [3:0] le, input int nc, input int ne);
    exp_t e;
    ev1 = ev; ed1 = DW'(ed); vo1 = vo; o1 = DW'(od);
    if (vo && trk1) begin e.le = le; e.nc = nc; e.ne = ne; q1.push_back(e); end
    @(negedge clk);
  endtask

  task automatic cyc4(input logic ev, input logic [4*DW-1:0] ed, input logic vo,
                      input logic [4*DW-1:0] od, input logic [3:0] le, input int nc, input int ne);
    exp_t e;
    ev4 = ev; ed4 = ed; vo4 = vo; o4 = od;
    if (vo && trk4) begin e.le = le; e.nc = nc; e.ne = ne; q4.push_back(e); end
    @(negedge clk);
  endtask

  task automatic reset1(input string nm);
    rst1 = 1'b1; ev1 = 1'b0; vo1 = 1'b0; trk1 = 1'b1;
    repeat (2) @(negedge clk);
    chk({nm, "_rst_outs"}, 128'({er1, le1, nc1, ne1, es1, ps1}), 128'(0));
    rst1 = 1'b0;
    @(negedge clk);
    chk({nm, "_rdy_after_rst"}, 128'(er1), 128'(1));
  endtask

  task automatic wait_end1(input string nm, input logic exp_pass);
    int n = 0;
    while (!es1 && n < 10) begin @(negedge clk); n++; end
    chk({nm, "_end_sim"}, 128'(es1), 128'(1));
    chk({nm, "_pass"}, 128'(ps1), 128'(exp_pass));
  endtask

  // Streams 8 beats with occupancy 1; beat 'bad' (if >=0) is corrupted.
  task automatic run_seq(input string nm, input int bad);
    int nerr = 0;
    reset1(nm);
    cyc1(1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      if (k - 1 == bad) nerr++;
      cyc1(k < 8, k, 1, (k - 1 == bad) ? 32'h1FFFF : k - 1,
           (k - 1 == bad) ? 4'd1 : 4'd0, k, nerr);
    end
    cyc1(0, 0, 0, 0, 0, 0, 0);
    wait_end1(nm, bad < 0);
    chk({nm, "_final_n_errors"}, 128'(ne1), 128'((bad < 0) ? 0 : 1));
  endtask

  function automatic logic [4*DW-1:0] beat4(input int k);
    logic [4*DW-1:0] b;
    for (int i = 0; i < 4; i++) b[i*DW +: DW] = DW'(k * 16 + i);
    return b;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    logic [4*DW-1:0] got4;
    @(negedge clk);

    // T1 / T2: clean stream, then beat 3 corrupted.
    run_seq("t1", -1);
    run_seq("t2", 3);

    // T3: fill, push+pop while full across pointer wrap, then drain.
    reset1("t3");
    for (int k = 0; k < 4; k++) cyc1(1, 10 + k, 0, 0, 0, 0, 0);
    chk("t3_full_ready", 128'(er1), 128'(0));
    for (int k = 0; k < 4; k++) begin
      cyc1(1, 14 + k, 1, 10 + k, 0, k + 1, 0);
      chk("t3_pushpop_ready", 128'(er1), 128'(0));
    end
    for (int k = 0; k < 4; k++) begin
      cyc1(0, 0, 1, 14 + k, 0, 5 + k, 0);
      if (k == 0) chk("t3_ready_after_pop", 128'(er1), 128'(1));
    end
    cyc1(0, 0, 0, 0, 0, 0, 0);
    wait_end1("t3", 1'b1);

    // T4a: underflow after reset, then further Vout is ignored.
    reset1("t4a");
    cyc1(0, 0, 1, 0, 4'd1, 1, 1);
    chk("t4a_end_sim", 128'(es1), 128'(1));
    chk("t4a_pass", 128'(ps1), 128'(0));
    trk1 = 1'b0;
    cyc1(1, 3, 1, 3, 0, 0, 0);
    cyc1(0, 0, 0, 0, 0, 0, 0);
    chk("t4a_frozen", 128'({le1, nc1, ne1}), 128'({1'b0, 16'd1, 16'd1}));

    // T4b: same-cycle push into empty FIFO is still underflow.
    reset1("t4b");
    cyc1(1, 0, 1, 0, 4'd1, 1, 1);
    chk("t4b_end_sim_pass", 128'({es1, ps1}), 128'({1'b1, 1'b0}));

    // T5: watchdog.
    reset1("t5");
    cyc1(1, 5, 0, 0, 0, 0, 0);
    ev1 = 1'b0;
    n = 0;
    while (!es1 && n < 40) begin @(negedge clk); n++; end
    chk("t5_timeout_cycle", 128'(n), 128'(TMO));
    chk("t5_pass_counts", 128'({ps1, nc1, ne1}), 128'(0));
`ifdef PE_CHECK_FIRST_ERR_EN
    chk("t5_first_err_vld", 128'(fv1), 128'(0));
`endif

    // T6: 4 lanes, lane 2 of beat 5 wrong, then a 1-cycle reset mid-run.
    rst1 = 1'b1;
    rst4 = 1'b1;
    repeat (2) @(negedge clk);
    rst4 = 1'b0;
    @(negedge clk);
    chk("t6_rdy_after_rst", 128'(er4), 128'(1));
    cyc4(1, beat4(0), 0, '0, 0, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      got4 = beat4(k - 1);
      if (k - 1 == 5) got4[2*DW +: DW] = DW'(17'h00ABC);
      cyc4(1, beat4(k), 1, got4, (k - 1 == 5) ? 4'b0100 : 4'b0000, k, (k - 1 >= 5) ? 1 : 0);
    end
`ifdef PE_CHECK_FIRST_ERR_EN
    chk("t6_first_err_idx", 128'({fv4, fi4}), 128'({1'b1, 16'd5}));
    got4 = beat4(5);
    got4[2*DW +: DW] = DW'(17'h00ABC);
    chk("t6_first_err_got", 128'(fg4), 128'(got4));
    chk("t6_first_err_exp", 128'(fx4), 128'(beat4(5)));
`endif
    rst4 = 1'b1; ev4 = 1'b0; vo4 = 1'b0;
    @(negedge clk);
    chk("t6_mid_reset", 128'({er4, le4, nc4, ne4, es4, ps4}), 128'(0));
`ifdef PE_CHECK_FIRST_ERR_EN
    chk("t6_mid_reset_first_err", 128'({fv4, fi4}), 128'(0));
`endif
    rst4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 128'(q1.size() + q4.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
